// File: rtl/gmac_tx_arbiter.sv
// gmac_tx_arbiter: shares one gig_eth_mac TX client port between two frame
// sources. Whole frames are granted round-robin, the owner's data/dvld/ack
// are passed through untouched, an idle gap is enforced after every grant,
// and a grant whose MAC ack never arrives is aborted after ACK_TIMEOUT cycles.
module gmac_tx_arbiter #(
    parameter int unsigned IFG_CYCLES  = 12,    // 1..255
    parameter int unsigned ACK_TIMEOUT = 1023   // 1..65535
) (
    input  logic        tx_clk,
    input  logic        reset,
    input  logic        conf_tx_en,
    input  logic [7:0]  req0_data,
    input  logic        req0_dvld,
    output logic        req0_ack,
    input  logic [7:0]  req1_data,
    input  logic        req1_dvld,
    output logic        req1_ack,
    output logic [7:0]  mac_tx_data,
    output logic        mac_tx_dvld,
    input  logic        mac_tx_ack,
    output logic [1:0]  grant,
    output logic [15:0] frame_cnt0,
    output logic [15:0] frame_cnt1,
    output logic [15:0] timeout_cnt
);

    typedef enum logic [1:0] {IDLE, WAIT_ACK, STREAM, GAP} state_t;

    localparam logic [7:0]  IFG_LOAD = 8'(IFG_CYCLES);
    localparam logic [15:0] TO_LAST  = 16'(ACK_TIMEOUT - 1);

    state_t      state_q;
    logic [1:0]  grant_q;
    logic        last_q;         // index of the requester granted most recently
    logic [7:0]  gap_q;
    logic [15:0] to_q;
    logic [15:0] frame_cnt0_q;
    logic [15:0] frame_cnt1_q;
    logic [15:0] timeout_cnt_q;

    logic        owner_dvld;
    logic        in_frame;
    logic        pick0;

    // Steer the owner's signals to the MAC and the MAC ack back to the owner.
    always_comb begin
        // NOTE: every output of this block gets a default first, so no path leaves a latch behind.
        owner_dvld  = 1'b0;
        mac_tx_data = 8'h00;
        if (grant_q[0]) begin
            owner_dvld  = req0_dvld;
            mac_tx_data = req0_data;
        end else if (grant_q[1]) begin
            owner_dvld  = req1_dvld;
            mac_tx_data = req1_data;
        end
        in_frame    = (state_q == WAIT_ACK) || (state_q == STREAM);
        mac_tx_dvld = owner_dvld & in_frame;
        req0_ack    = mac_tx_ack & grant_q[0] & in_frame;
        req1_ack    = mac_tx_ack & grant_q[1] & in_frame;
        // Requester 0 wins when alone, or on a tie when requester 1 went last.
        pick0       = req0_dvld & (~req1_dvld | last_q);
    end

    // Frame-level arbitration FSM with its counters and registered grant.
    always_ff @(posedge tx_clk or posedge reset) begin
        if (reset) begin
            state_q       <= IDLE;
            grant_q       <= 2'b00;
            last_q        <= 1'b1;
            gap_q         <= 8'd0;
            to_q          <= 16'd0;
            frame_cnt0_q  <= 16'd0;
            frame_cnt1_q  <= 16'd0;
            timeout_cnt_q <= 16'd0;
        end else begin
            // NOTE: non-blocking assignments so every register here updates from pre-edge values.
            case (state_q)
                IDLE: begin
                    if (conf_tx_en && (req0_dvld || req1_dvld)) begin
                        grant_q <= pick0 ? 2'b01 : 2'b10;
                        last_q  <= ~pick0;
                        to_q    <= 16'd0;
                        state_q <= WAIT_ACK;
                    end
                end
                WAIT_ACK: begin
                    if (mac_tx_ack) begin
                        state_q <= STREAM;
                    end else if (!owner_dvld) begin
                        // Source withdrew before the MAC took the first byte.
                        grant_q <= 2'b00;
                        gap_q   <= IFG_LOAD;
                        state_q <= GAP;
                    end else if (to_q == TO_LAST) begin
                        timeout_cnt_q <= timeout_cnt_q + 16'd1;
                        grant_q       <= 2'b00;
                        gap_q         <= IFG_LOAD;
                        state_q       <= GAP;
                    end else begin
                        to_q <= to_q + 16'd1;
                    end
                end
                STREAM: begin
                    if (!owner_dvld) begin
                        if (grant_q[0]) begin
                            frame_cnt0_q <= frame_cnt0_q + 16'd1;
                        end else begin
                            frame_cnt1_q <= frame_cnt1_q + 16'd1;
                        end
                        grant_q <= 2'b00;
                        gap_q   <= IFG_LOAD;
                        state_q <= GAP;
                    end
                end
                GAP: begin
                    if (gap_q <= 8'd1) begin
                        gap_q   <= 8'd0;
                        state_q <= IDLE;
                    end else begin
                        gap_q <= gap_q - 8'd1;
                    end
                end
                default: begin
                    grant_q <= 2'b00;
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign grant       = grant_q;
    assign frame_cnt0  = frame_cnt0_q;
    assign frame_cnt1  = frame_cnt1_q;
    assign timeout_cnt = timeout_cnt_q;

endmodule

// File: tb/tb_gmac_tx_arbiter.sv
// tb_gmac_tx_arbiter: bench for gmac_tx_arbiter. Requester models push every
// byte they offer into a per-source scoreboard queue; a MAC model acks after
// a programmable delay and pops/compares each byte it takes.
module tb_gmac_tx_arbiter;

    localparam int IFG = 5;
    localparam int TO  = 16;

    typedef struct {
        int          src;
        int          len;
        int          ack_dly;
        logic [1:0]  exp_grant;
        logic [15:0] exp_cnt0;
        logic [15:0] exp_cnt1;
    } vec_t;

    logic        tx_clk     = 1'b0;
    logic        reset      = 1'b1;
    logic        conf_tx_en = 1'b1;
    logic [7:0]  req0_data  = 8'h00;
    logic        req0_dvld  = 1'b0;
    logic [7:0]  req1_data  = 8'h00;
    logic        req1_dvld  = 1'b0;
    logic        mac_tx_ack = 1'b0;
    logic        req0_ack, req1_ack;
    logic [7:0]  mac_tx_data;
    logic        mac_tx_dvld;
    logic [1:0]  grant;
    logic [15:0] frame_cnt0, frame_cnt1, timeout_cnt;

    int          n_checks = 0;
    int          n_pass   = 0;
    logic [7:0]  sb0[$];
    logic [7:0]  sb1[$];
    bit          ack_en    = 1'b1;
    bit          stray_ack = 1'b0;
    bit          abort_req = 1'b0;
    int          ack_dly   = 2;
    logic [1:0]  grant_log[$];
    int          gap_log[$];
    int          zero_run   = 0;
    logic [1:0]  prev_grant = 2'b00;
    int          exp_c0 = 0, exp_c1 = 0, exp_to = 0;

    gmac_tx_arbiter #(.IFG_CYCLES(IFG), .ACK_TIMEOUT(TO)) dut (
        .tx_clk      (tx_clk),
        .reset       (reset),
        .conf_tx_en  (conf_tx_en),
        .req0_data   (req0_data),
        .req0_dvld   (req0_dvld),
        .req0_ack    (req0_ack),
        .req1_data   (req1_data),
        .req1_dvld   (req1_dvld),
        .req1_ack    (req1_ack),
        .mac_tx_data (mac_tx_data),
        .mac_tx_dvld (mac_tx_dvld),
        .mac_tx_ack  (mac_tx_ack),
        .grant       (grant),
        .frame_cnt0  (frame_cnt0),
        .frame_cnt1  (frame_cnt1),
        .timeout_cnt (timeout_cnt)
    );

    always #5 tx_clk = ~tx_clk;

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached, got no summary, required finish");
        $fatal(1);
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            $display("FAIL %s: got %0h required %0h (t=%0t)", name, act, exp, $time);
        end else begin
            n_pass++;
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge tx_clk);
        #1;
    endtask

    task automatic drive(input int src, input logic v, input logic [7:0] d);
        if (src == 0) begin
            req0_dvld = v;
            req0_data = d;
        end else begin
            req1_dvld = v;
            req1_data = d;
        end
    endtask

    // Requester model: holds byte 0 until acked, then one byte per cycle.
    task automatic send_frame(input int src, input int len, input int max_cyc,
                              output int sent, output int acks);
        logic [7:0] f[$];
        int idx, cyc;
        bit started, ack_s;
        for (int i = 0; i < len; i++) begin
            f.push_back(8'($urandom));
            if (src == 0) sb0.push_back(f[i]);
            else          sb1.push_back(f[i]);
        end
        idx = 0; cyc = 0; started = 1'b0; acks = 0;
        drive(src, 1'b1, f[0]);
        while (idx < len && cyc < max_cyc && !abort_req) begin
            @(negedge tx_clk);
            ack_s = (src == 0) ? req0_ack : req1_ack;
            if (ack_s) acks++;
            @(posedge tx_clk);
            #1;
            cyc++;
            if (ack_s) started = 1'b1;
            if (started) idx++;
            if (idx < len) drive(src, 1'b1, f[idx]);
        end
        drive(src, 1'b0, 8'h00);
        sent = idx;
        tick(1);
    endtask

    // MAC model: acks ack_dly cycles after dvld rises, then takes one byte per cycle.
    initial begin : mac_model
        int  wcnt;
        bit  mstarted, ack_next;
        logic [7:0] exp_b;
        wcnt = 0; mstarted = 1'b0; ack_next = 1'b0;
        forever begin
            @(negedge tx_clk);
            if (!mac_tx_dvld) begin
                wcnt = 0;
                mstarted = 1'b0;
            end else begin
                if (mac_tx_ack || mstarted) begin
                    if (grant[0] && sb0.size() > 0) begin
                        exp_b = sb0.pop_front();
                        check("byte_src0", 32'(mac_tx_data), 32'(exp_b));
                    end else if (grant[1] && sb1.size() > 0) begin
                        exp_b = sb1.pop_front();
                        check("byte_src1", 32'(mac_tx_data), 32'(exp_b));
                    end else begin
                        n_checks++;
                        $display("FAIL byte_extra: got %0h required no byte (grant %b)", mac_tx_data, grant);
                    end
                end
                if (mac_tx_ack) begin
                    mstarted = 1'b1;
                end else if (!mstarted) begin
                    wcnt++;
                    if (ack_en && wcnt == ack_dly) ack_next = 1'b1;
                end
            end
            @(posedge tx_clk);
            #1;
            mac_tx_ack = ack_next | stray_ack;
            ack_next   = 1'b0;
        end
    end

    // Grant/gap logger and ack routing check.
    initial begin : grant_monitor
        forever begin
            @(negedge tx_clk);
            if (grant != 2'b00 && prev_grant == 2'b00) begin
                grant_log.push_back(grant);
                gap_log.push_back(zero_run);
            end
            if (grant == 2'b00) zero_run++;
            else                zero_run = 0;
            prev_grant = grant;
            if (req0_ack || req1_ack) check("ack_route", 32'({req1_ack, req0_ack}), 32'(grant));
        end
    end

    initial begin : main
        vec_t vecs[5];
        int   sent, acks;
        logic bad;

        vecs[0] = '{0, 64, 3, 2'b01, 16'd1, 16'd0};
        vecs[1] = '{1, 10, 1, 2'b10, 16'd1, 16'd1};
        vecs[2] = '{0,  1, 5, 2'b01, 16'd2, 16'd1};
        vecs[3] = '{1,  2, 2, 2'b10, 16'd2, 16'd2};
        vecs[4] = '{1,  3, 4, 2'b10, 16'd2, 16'd3};

        // Reset values while reset is held.
        tick(3);
        check("rst_grant", 32'(grant), 32'd0);
        check("rst_dvld", 32'(mac_tx_dvld), 32'd0);
        check("rst_data", 32'(mac_tx_data), 32'd0);
        check("rst_acks", 32'({req1_ack, req0_ack}), 32'd0);
        check("rst_cnts", {frame_cnt0, frame_cnt1} | 32'(timeout_cnt), 32'd0);
        reset = 1'b0;
        tick(2);

        // Single-source frames from the vector table.
        for (int i = 0; i < 5; i++) begin
            ack_dly = vecs[i].ack_dly;
            fork
                send_frame(vecs[i].src, vecs[i].len, 2000, sent, acks);
                begin
                    repeat (2) @(negedge tx_clk);
                    check("vec_grant", 32'(grant), 32'(vecs[i].exp_grant));
                end
            join
            check("vec_sent", 32'(sent), 32'(vecs[i].len));
            check("vec_acks", 32'(acks), 32'd1);
            check("vec_cnt0", 32'(frame_cnt0), 32'(vecs[i].exp_cnt0));
            check("vec_cnt1", 32'(frame_cnt1), 32'(vecs[i].exp_cnt1));
            check("vec_sb_empty", 32'(sb0.size() + sb1.size()), 32'd0);
            tick(IFG + 3);
        end
        exp_c0 = 2; exp_c1 = 3;

        // Stray MAC ack while idle is not forwarded.
        @(negedge tx_clk);
        stray_ack = 1'b1;
        @(negedge tx_clk);
        check("stray_ack_routed", 32'({req1_ack, req0_ack}), 32'd0);
        stray_ack = 1'b0;
        @(negedge tx_clk);
        check("stray_ack_grant", 32'(grant), 32'd0);
        tick(2);

        // Both sources continuously valid: alternating grants, fixed gap.
        grant_log.delete();
        gap_log.delete();
        ack_dly = 2;
        fork
            begin
                int s0, a0;
                for (int k = 0; k < 4; k++) begin
                    send_frame(0, 8, 2000, s0, a0);
                    check("rr_sent0", 32'(s0), 32'd8);
                end
            end
            begin
                int s1, a1;
                for (int k = 0; k < 4; k++) begin
                    send_frame(1, 8, 2000, s1, a1);
                    check("rr_sent1", 32'(s1), 32'd8);
                end
            end
        join
        exp_c0 += 4; exp_c1 += 4;
        check("rr_grants", 32'(grant_log.size()), 32'd8);
        for (int i = 0; i < grant_log.size(); i++) begin
            check("rr_order", 32'(grant_log[i]), (i % 2 == 0) ? 32'd1 : 32'd2);
            if (i > 0) check("rr_gap", 32'(gap_log[i]), 32'(IFG + 1));
        end
        check("rr_cnt0", 32'(frame_cnt0), 32'(exp_c0));
        check("rr_cnt1", 32'(frame_cnt1), 32'(exp_c1));
        tick(IFG + 3);

        // Ack timeout on requester 1, then a normal requester 0 frame.
        ack_en = 1'b0;
        fork
            send_frame(1, 4, 20, sent, acks);
            begin
                repeat (17) @(negedge tx_clk);
                check("to_before_cnt", 32'(timeout_cnt), 32'(exp_to));
                check("to_before_dvld", 32'(mac_tx_dvld), 32'd1);
                @(negedge tx_clk);
                exp_to++;
                check("to_after_cnt", 32'(timeout_cnt), 32'(exp_to));
                check("to_after_dvld", 32'(mac_tx_dvld), 32'd0);
                check("to_after_grant", 32'(grant), 32'd0);
            end
        join
        check("to_not_sent", 32'(sent), 32'd0);
        sb1.delete();
        ack_en = 1'b1;
        tick(IFG + 3);
        send_frame(0, 6, 2000, sent, acks);
        exp_c0++;
        check("to_next_sent", 32'(sent), 32'd6);
        check("to_next_cnt0", 32'(frame_cnt0), 32'(exp_c0));
        tick(IFG + 3);

        // Requester withdraws before ack: no counter moves.
        ack_dly = 10;
        send_frame(1, 4, 3, sent, acks);
        sb1.delete();
        tick(IFG + 3);
        check("cancel_cnt1", 32'(frame_cnt1), 32'(exp_c1));
        check("cancel_to", 32'(timeout_cnt), 32'(exp_to));
        ack_dly = 2;

        // conf_tx_en low blocks arbitration; raising it grants next cycle.
        conf_tx_en = 1'b0;
        fork
            send_frame(0, 8, 1000, sent, acks);
            begin
                bad = 1'b0;
                repeat (100) begin
                    @(negedge tx_clk);
                    if (grant != 2'b00 || mac_tx_dvld) bad = 1'b1;
                end
                check("en_low_blocked", 32'(bad), 32'd0);
                @(posedge tx_clk);
                #1;
                conf_tx_en = 1'b1;
                repeat (2) @(negedge tx_clk);
                check("en_high_grant", 32'(grant), 32'd1);
            end
        join
        exp_c0++;
        check("en_sent", 32'(sent), 32'd8);
        check("en_cnt0", 32'(frame_cnt0), 32'(exp_c0));
        tick(IFG + 3);

        // conf_tx_en drops mid-frame: frame completes, no new grant follows.
        fork
            send_frame(0, 100, 2000, sent, acks);
            begin
                repeat (30) @(negedge tx_clk);
                @(posedge tx_clk);
                #1;
                conf_tx_en = 1'b0;
            end
        join
        exp_c0++;
        check("drop_sent", 32'(sent), 32'd100);
        check("drop_sb_empty", 32'(sb0.size()), 32'd0);
        check("drop_cnt0", 32'(frame_cnt0), 32'(exp_c0));
        fork
            send_frame(1, 4, 40, sent, acks);
            begin
                bad = 1'b0;
                repeat (40) begin
                    @(negedge tx_clk);
                    if (grant != 2'b00) bad = 1'b1;
                end
                check("drop_no_grant", 32'(bad), 32'd0);
            end
        join
        sb1.delete();
        conf_tx_en = 1'b1;
        tick(IFG + 3);

        // Asynchronous reset mid-stream, then requester 0 preferred again.
        fork
            send_frame(0, 50, 2000, sent, acks);
            begin
                repeat (10) @(negedge tx_clk);
                @(posedge tx_clk);
                #1;
                check("rst_mid_pre_grant", 32'(grant), 32'd1);
                reset = 1'b1;
                abort_req = 1'b1;
                #1;
                check("rst_mid_dvld", 32'(mac_tx_dvld), 32'd0);
                check("rst_mid_grant", 32'(grant), 32'd0);
                check("rst_mid_data", 32'(mac_tx_data), 32'd0);
                check("rst_mid_cnt0", 32'(frame_cnt0), 32'd0);
                check("rst_mid_cnt1", 32'(frame_cnt1), 32'd0);
                check("rst_mid_to", 32'(timeout_cnt), 32'd0);
            end
        join
        sb0.delete();
        sb1.delete();
        exp_c0 = 0; exp_c1 = 0; exp_to = 0;
        tick(2);
        abort_req = 1'b0;
        reset = 1'b0;
        fork
            begin
                int s0, a0;
                send_frame(0, 5, 2000, s0, a0);
                check("post_rst_sent0", 32'(s0), 32'd5);
            end
            begin
                int s1, a1;
                send_frame(1, 5, 2000, s1, a1);
                check("post_rst_sent1", 32'(s1), 32'd5);
            end
            begin
                repeat (2) @(negedge tx_clk);
                check("post_rst_first_grant", 32'(grant), 32'd1);
            end
        join
        exp_c0++; exp_c1++;
        check("post_rst_cnt0", 32'(frame_cnt0), 32'(exp_c0));
        check("post_rst_cnt1", 32'(frame_cnt1), 32'(exp_c1));
        check("post_rst_to", 32'(timeout_cnt), 32'(exp_to));

        tick(4);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/gmac_tx_arbiter.md
Name: gmac_tx_arbiter

Overview:
- Shares one gig_eth_mac TX client interface between two frame sources.
  - Requester 0: frame_sender probe traffic.
  - Requester 1: second source, e.g. echo/reply path.
- Arbitrates per whole frame with round-robin.
- Forwards the granted source's data, dvld and ack unmodified, and enforces a minimum idle gap between grants.
- Aborts a grant whose MAC ack never arrives, and keeps per-source frame counters and a timeout counter.

Parameters:
- IFG_CYCLES, 12: idle cycles in GAP after every grant ends, before the next arbitration; valid range 1..255.
- ACK_TIMEOUT, 1023: maximum cycles in WAIT_ACK before the grant is aborted; valid range 1..65535.

Ports:
- tx_clk  in  1  TX client clock; all logic on rising edge.
- reset  in  1  asynchronous, active-high reset.
- conf_tx_en  in  1  when low, no new grant is issued.
- req0_data  in  8  requester 0 byte.
- req0_dvld  in  1  requester 0 frame valid; held high for the whole frame.
- req0_ack  out  1  MAC ack routed to requester 0.
- req1_data  in  8  requester 1 byte.
- req1_dvld  in  1  requester 1 frame valid.
- req1_ack  out  1  MAC ack routed to requester 1.
- mac_tx_data  out  8  to MAC.
- mac_tx_dvld  out  1  to MAC.
- mac_tx_ack  in  1  from MAC; pulses when the first byte is taken.
- grant  out  2  one-hot current owner; 00 when none.
- frame_cnt0  out  16  completed frames from requester 0.
- frame_cnt1  out  16  completed frames from requester 1.
- timeout_cnt  out  16  grants aborted by ack timeout.

Behaviour:
- Reset values:
  - state=IDLE, grant=00, last=1 (requester 0 wins the first tie), all counters 0.
  - gap/timeout counters 0; mac_tx_dvld=0, mac_tx_data=0, req*_ack=0.
- Output muxing:
  - mac_tx_data = data of the granted requester, else 0.
  - mac_tx_dvld = dvld of the granted requester AND state in {WAIT_ACK, STREAM}.
  - reqN_ack = mac_tx_ack AND grant[N]. Combinational, zero latency.
- States: IDLE, WAIT_ACK, STREAM, GAP.
- IDLE:
  - Arbitration runs only if conf_tx_en=1 and (req0_dvld | req1_dvld).
  - One requester: grant it. Both: grant the one not equal to last.
  - grant and last are registered; go to WAIT_ACK.
  - Latency: dvld sampled high in cycle N gives grant and mac_tx_dvld high in cycle N+1.
- WAIT_ACK:
  - Timeout counter increments each cycle in this state.
  - mac_tx_ack=1: go to STREAM; ack is forwarded to the owner that cycle.
  - Owner dvld=0 before ack: cancelled request; go to GAP, no counter change.
  - Counter reaches ACK_TIMEOUT without ack: timeout_cnt++, go to GAP. mac_tx_dvld is 0 from the next cycle.
  - If ack and timeout occur in the same cycle, ack wins.
- STREAM:
  - Pass-through while owner dvld=1.
  - Owner dvld=0: frame_cntN++, go to GAP.
  - No length limit is enforced; the MAC handles jumbo and oversize frames.
- GAP:
  - grant=00, mac_tx_dvld=0.
  - Load the gap counter with IFG_CYCLES on entry; go to IDLE when it reaches 0.
  - Requests arriving in GAP wait; no frame is lost, since requesters hold dvld until acked.
- conf_tx_en is sampled only in IDLE. Deasserting it mid-frame neither aborts nor truncates the frame.
- Counters wrap modulo 2^16.
- Reset asserted mid-frame: all outputs drop to reset values immediately (asynchronous). The frame is truncated and the MAC sees dvld fall. After reset, arbitration restarts with requester 0 preferred.
- mac_tx_ack received outside WAIT_ACK/STREAM is ignored and not forwarded.

Test Plan:
1. Single source: req0 frame of 64 bytes, ack 3 cycles after mac_tx_dvld rises.
   - grant=01 the cycle after req0_dvld.
   - mac_tx_data equals req0_data byte-for-byte; req0_ack pulses once.
   - frame_cnt0=1; after dvld falls, no grant for exactly IFG_CYCLES+1 cycles (GAP plus the IDLE decision cycle).
2. Simultaneous requests: req0 and req1 both continuously valid, 4 frames each.
   - Grants alternate 01,10,01,10... starting with 01.
   - frame_cnt0=frame_cnt1=4; req1_ack never pulses during req0 ownership.
3. Ack timeout (ACK_TIMEOUT=16): req1 valid, MAC never acks.
   - After 16 cycles in WAIT_ACK: timeout_cnt=1, mac_tx_dvld=0, state passes through GAP.
   - A subsequent acked req0 frame completes normally.
4. conf_tx_en=0 with req0 valid: grant stays 00 and mac_tx_dvld=0 for 100 cycles. Raise conf_tx_en: grant=01 within 1 cycle.
5. conf_tx_en drops mid-STREAM of a 100-byte frame: all 100 bytes are forwarded, frame_cnt0 increments, and no new grant follows while it stays low.
6. Reset mid-STREAM: mac_tx_dvld=0, grant=00 and all counters 0 asynchronously. After release with both requests pending, the first grant is 01.
